pixel_window3: RTL and testbench
================================

# pixel_window3

Streaming 3-tap horizontal window generator for the real-time pixel path. It consumes one pixel per cycle from the upstream capture/register stage and emits, for every pixel, the triple (left, center, right) with defined edge handling at line boundaries. It is the first neighbourhood stage feeding the 1-D filter kernels. The block is registered throughout, has no backpressure, and runs at pixel rate.

## Interface
- DW, 8: pixel data width in bits.
- MAX_W, 640: maximum pixels per line; column counter width CW = $clog2(MAX_W).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk. One clock; the reset is asynchronous and active-low.
- in_valid  in  1  pixel present this cycle.
- in_sol  in  1  start of line, qualified by in_valid.
- in_eol  in  1  end of line, qualified by in_valid; may coincide with in_sol.
- in_pixel  in  DW  pixel data.
- out_valid  out  1  window valid.
- out_sol / out_eol  out  1 each  center pixel is first / last of its line.
- out_left / out_center / out_right  out  DW each  window taps.
- out_col  out  CW  column index of center pixel.
- line_err  out  1  sticky protocol-error flag.

## Operation
- All outputs reset to 0; FSM resets to IDLE; taps and column counter reset to 0.
- FSM states: IDLE, FILL, RUN, FLUSH.
- IDLE: in_valid&in_sol captures the pixel as center candidate, col=0 -> FILL; with in_eol also set -> FLUSH. in_valid without in_sol is dropped, sets line_err.
- FILL: the next valid pixel becomes right; emit window for col 0 (left = edge value) -> RUN, or -> FLUSH if in_eol.
- RUN: each valid pixel shifts left<-center<-right<-in_pixel and emits a window for the previous center; in_eol -> FLUSH.
- FLUSH: exactly one cycle, independent of in_valid; emits the final pixel with right = edge value, out_eol=1 -> IDLE. If in_valid&in_sol arrives in the FLUSH cycle, it is accepted as the new line start (-> FILL or FLUSH) in the same cycle the flush window is emitted.
- Gaps (in_valid=0) in FILL/RUN hold all state; out_valid=0.
- in_sol in FILL/RUN: current line is abandoned without emitting the pending pixel, line_err=1, and the new pixel restarts the line as from IDLE.
- Column counter saturates at MAX_W-1; a line exceeding MAX_W sets line_err, and windows continue with out_col held.
- line_err clears only on reset.

## Timing
- Latency: a window centered on pixel i appears on the cycle after pixel i+1 is accepted (registered output), or on the FLUSH cycle for the last pixel.
- A line of N pixels yields exactly N windows; the last window appears one cycle after the eol beat.
- out_sol/out_eol are asserted on the window's out_valid cycle only.
- Reset asserted mid-line: all outputs drop to 0 asynchronously, the FSM returns to IDLE, and no partial window is emitted afterwards.

## Configuration
- PIXEL_WINDOW3_EDGE_REPLICATE_EN defined: the edge value equals the center pixel, so the first window is (p0,p0,p1) and the last is (pN-2,pN-1,pN-1).
- Not defined: the edge value is 0 (zero padding), so the first window is (0,p0,p1).

## Structure
- pixel_window3_pkg holds the state enum (IDLE/FILL/RUN/FLUSH), default DW/MAX_W constants, and a window struct type {left,center,right}.
- Single module; no sub-module is warranted, as the tap registers are three flops and are not worth a separate block.

## Test plan
- Line 10,20,30,40 (sol on 10, eol on 40), replicate on -> windows (10,10,20) (10,20,30) (20,30,40) (30,40,40), col 0..3, sol on first, eol on last, 4 out_valid total.
- Same line, macro off -> first (0,10,20), last (30,40,0).
- Single-pixel line 55 with sol&eol -> one FLUSH window (55,55,55) with out_sol=out_eol=1; then back-to-back line starting in the FLUSH cycle is accepted without loss.
- Line 1,2,3 with in_valid gaps of 3 cycles between pixels -> identical windows to the gapless case, with out_valid only on acceptance cycles +1.
- in_sol mid-line after 2 pixels -> line_err=1, stays 1, no window for the abandoned center, and the new line starts at col 0.
- Reset pulse (reset=0) during RUN -> outputs 0 immediately; a pixel without sol after release is dropped and line_err=1.

Source files
------------

// File: rtl/pixel_window3_pkg.sv
// Shared types and defaults for the 3-tap horizontal window generator.
package pixel_window3_pkg;

  localparam int DW_DEF    = 8;
  localparam int MAX_W_DEF = 640;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [DW_DEF-1:0] left;
    logic [DW_DEF-1:0] center;
    logic [DW_DEF-1:0] right;
  } window_t;

endpackage

// File: rtl/pixel_window3_if.sv
// Pixel stream in, window stream out; master drives pixels, slave produces windows.
interface pixel_window3_if #(
  parameter int DW = 8,
  parameter int CW = 10
);
  logic          in_valid;
  logic          in_sol;
  logic          in_eol;
  logic [DW-1:0] in_pixel;

  logic          out_valid;
  logic          out_sol;
  logic          out_eol;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_center;
  logic [DW-1:0] out_right;
  logic [CW-1:0] out_col;
  logic          line_err;

  modport master (
    output in_valid, in_sol, in_eol, in_pixel,
    input  out_valid, out_sol, out_eol, out_left, out_center, out_right, out_col, line_err
  );

  modport slave (
    input  in_valid, in_sol, in_eol, in_pixel,
    output out_valid, out_sol, out_eol, out_left, out_center, out_right, out_col, line_err
  );
endinterface

// File: rtl/pixel_window3.sv
// Streaming 3-tap horizontal window (left, center, right) with line-edge handling.
// PIXEL_WINDOW3_EDGE_REPLICATE_EN: edge taps repeat the center pixel instead of zero.
//
// state | meaning
// IDLE  | waiting for a start-of-line pixel
// FILL  | first pixel held as center, waiting for its right neighbour
// RUN   | mid-line, each pixel emits the window of the previous center
// FLUSH | eol seen, emit last window with right edge (one cycle)
module pixel_window3
  import pixel_window3_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int MAX_W = MAX_W_DEF,
  localparam int CW    = $clog2(MAX_W)
) (
  input logic            clk,
  input logic            reset,
  pixel_window3_if.slave pw
);

  typedef struct packed {
    logic [DW-1:0] left;
    logic [DW-1:0] center;
    logic [DW-1:0] right;
  } win_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] left_q;
  logic [DW-1:0] center_q;
  logic [CW-1:0] col_q;
  logic [DW-1:0] edge_v;
  logic          start;
  logic          at_first;
  logic          col_sat;
  logic          emit;
  logic          emit_eol;
  logic          restart;
  logic          shift;
  logic          err_set;
  win_t          win;

`ifdef PIXEL_WINDOW3_EDGE_REPLICATE_EN
  assign edge_v = center_q;
`else
  assign edge_v = '0;
`endif

  assign start    = pw.in_valid & pw.in_sol;
  assign at_first = (col_q == '0);
  assign col_sat  = (col_q == CW'(MAX_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    emit       = 1'b0;
    emit_eol   = 1'b0;
    restart    = 1'b0;
    shift      = 1'b0;
    err_set    = 1'b0;
    win.left   = at_first ? edge_v : left_q;
    win.center = center_q;
    win.right  = pw.in_pixel;
    case (state)
      IDLE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = pw.in_eol ? FLUSH : FILL;
        end else if (pw.in_valid) begin
          err_set = 1'b1;
        end
      end
      FILL, RUN: begin
        // a new sol abandons the pending center without emitting it
        if (start) begin
          restart  = 1'b1;
          err_set  = 1'b1;
          state_nx = pw.in_eol ? FLUSH : FILL;
        end else if (pw.in_valid) begin
          emit     = 1'b1;
          shift    = 1'b1;
          err_set  = col_sat;
          state_nx = pw.in_eol ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        emit      = 1'b1;
        emit_eol  = 1'b1;
        win.right = edge_v;
        state_nx  = IDLE;
        if (start) begin
          restart  = 1'b1;
          state_nx = pw.in_eol ? FLUSH : FILL;
        end else if (pw.in_valid) begin
          err_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q        <= '0;
      center_q      <= '0;
      col_q         <= '0;
      pw.out_valid  <= 1'b0;
      pw.out_sol    <= 1'b0;
      pw.out_eol    <= 1'b0;
      pw.out_left   <= '0;
      pw.out_center <= '0;
      pw.out_right  <= '0;
      pw.out_col    <= '0;
      pw.line_err   <= 1'b0;
    end else begin
      if (restart) begin
        center_q <= pw.in_pixel;
        col_q    <= '0;
      end else if (shift) begin
        left_q   <= center_q;
        center_q <= pw.in_pixel;
        if (!col_sat) col_q <= col_q + CW'(1);
      end
      pw.out_valid <= emit;
      pw.out_sol   <= emit & at_first;
      pw.out_eol   <= emit_eol;
      if (emit) begin
        pw.out_left   <= win.left;
        pw.out_center <= win.center;
        pw.out_right  <= win.right;
        pw.out_col    <= col_q;
      end
      if (err_set) pw.line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_window3.sv
// Directed bench for pixel_window3: line-array model checked every cycle plus literal window lists.
module tb_pixel_window3;
  import pixel_window3_pkg::*;

  localparam int DW    = 8;
  localparam int MAX_W = 8;
  localparam int CW    = $clog2(MAX_W);
`ifdef PIXEL_WINDOW3_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  typedef struct {
    window_t w;
    int      col;
    bit      sol;
    bit      eol;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t got[$];

  pixel_window3_if #(.DW(DW), .CW(CW)) pw ();

  pixel_window3 #(.DW(DW), .MAX_W(MAX_W)) dut (
    .clk  (clk),
    .reset(reset),
    .pw   (pw.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(input logic [7:0] c);
    return REPL ? c : 8'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pixels of the current line kept in a queue; windows derived by index.
  logic [7:0] line[$];
  bit         in_line;
  bit         flush_p;
  logic       m_valid, m_sol, m_eol, m_err;
  logic [7:0] m_l, m_c, m_r;
  int         m_col;

  task automatic model_emit(input int k, input logic [7:0] right);
    m_valid = 1'b1;
    m_c     = line[k];
    m_l     = (k == 0) ? ev(line[k]) : line[k-1];
    m_r     = right;
    m_col   = (k < MAX_W - 1) ? k : MAX_W - 1;
    m_sol   = (k == 0);
  endtask

  always @(posedge clk or negedge reset) begin
    int k;
    if (!reset) begin
      line.delete();
      in_line = 0; flush_p = 0;
      m_valid = 0; m_sol = 0; m_eol = 0; m_err = 0;
      m_l = 0; m_c = 0; m_r = 0; m_col = 0;
    end else begin
      m_valid = 0; m_sol = 0; m_eol = 0;
      if (flush_p) begin
        k = line.size() - 1;
        model_emit(k, ev(line[k]));
        m_eol   = 1'b1;
        flush_p = 0;
      end
      if (pw.in_valid) begin
        if (pw.in_sol) begin
          if (in_line) m_err = 1'b1;
          line.delete();
          line.push_back(pw.in_pixel);
          in_line = !pw.in_eol;
          flush_p = pw.in_eol;
        end else if (!in_line) begin
          m_err = 1'b1;
        end else begin
          line.push_back(pw.in_pixel);
          if (line.size() > MAX_W) m_err = 1'b1;
          model_emit(line.size() - 2, pw.in_pixel);
          if (pw.in_eol) begin
            in_line = 0;
            flush_p = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", pw.out_valid, m_valid);
    chk("out_sol", pw.out_sol, m_sol);
    chk("out_eol", pw.out_eol, m_eol);
    chk("line_err", pw.line_err, m_err);
    if (m_valid) begin
      chk("out_left", pw.out_left, m_l);
      chk("out_center", pw.out_center, m_c);
      chk("out_right", pw.out_right, m_r);
      chk("out_col", pw.out_col, m_col);
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (pw.out_valid === 1'b1) begin
      r.w.left   = pw.out_left;
      r.w.center = pw.out_center;
      r.w.right  = pw.out_right;
      r.col      = int'(pw.out_col);
      r.sol      = pw.out_sol;
      r.eol      = pw.out_eol;
      got.push_back(r);
    end
  end

  task automatic beat(input bit v, input bit s, input bit e, input logic [7:0] p);
    pw.in_valid = v; pw.in_sol = s; pw.in_eol = e; pw.in_pixel = p;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 8'd0);
  endtask

  task automatic check_win(input int i, input logic [7:0] l, input logic [7:0] c,
                           input logic [7:0] r, input int col, input bit sol, input bit eol);
    if (i >= got.size()) begin
      chk("win_present", got.size(), i + 1);
    end else begin
      chk("lit_left", got[i].w.left, l);
      chk("lit_center", got[i].w.center, c);
      chk("lit_right", got[i].w.right, r);
      chk("lit_col", got[i].col, col);
      chk("lit_sol", got[i].sol, sol);
      chk("lit_eol", got[i].eol, eol);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    pw.in_valid = 0; pw.in_sol = 0; pw.in_eol = 0; pw.in_pixel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pw.out_valid, 0);
    chk("rst_left", pw.out_left, 0);
    chk("rst_center", pw.out_center, 0);
    chk("rst_right", pw.out_right, 0);
    chk("rst_col", pw.out_col, 0);
    chk("rst_err", pw.line_err, 0);
    reset = 1'b1;
    idle(2);

    // basic 4-pixel line
    got.delete();
    beat(1, 1, 0, 8'd10); beat(1, 0, 0, 8'd20); beat(1, 0, 0, 8'd30); beat(1, 0, 1, 8'd40);
    idle(3);
    chk("line4_count", got.size(), 4);
    check_win(0, ev(10), 10, 20, 0, 1, 0);
    check_win(1, 10, 20, 30, 1, 0, 0);
    check_win(2, 20, 30, 40, 2, 0, 0);
    check_win(3, 30, 40, ev(40), 3, 0, 1);

    // single pixel line, next line starts in its flush cycle
    got.delete();
    beat(1, 1, 1, 8'd55); beat(1, 1, 0, 8'd1); beat(1, 0, 0, 8'd2); beat(1, 0, 1, 8'd3);
    idle(3);
    chk("single_count", got.size(), 4);
    check_win(0, ev(55), 55, ev(55), 0, 1, 1);
    check_win(1, ev(1), 1, 2, 0, 1, 0);
    check_win(3, 2, 3, ev(3), 2, 0, 1);

    // gaps between pixels
    got.delete();
    beat(1, 1, 0, 8'd1); idle(3); beat(1, 0, 0, 8'd2); idle(3); beat(1, 0, 1, 8'd3); idle(3);
    chk("gap_count", got.size(), 3);
    check_win(0, ev(1), 1, 2, 0, 1, 0);
    check_win(1, 1, 2, 3, 1, 0, 0);
    check_win(2, 2, 3, ev(3), 2, 0, 1);

    // two-pixel line
    got.delete();
    beat(1, 1, 0, 8'd7); beat(1, 0, 1, 8'd9); idle(3);
    chk("two_count", got.size(), 2);
    check_win(1, 7, 9, ev(9), 1, 0, 1);
    chk("err_clean", pw.line_err, 0);

    // overflow beyond MAX_W
    got.delete();
    for (int i = 0; i < 10; i++) beat(1, i == 0, i == 9, 8'(100 + i));
    idle(3);
    chk("ovf_count", got.size(), 10);
    check_win(7, 106, 107, 108, 7, 0, 0);
    check_win(8, 107, 108, 109, 7, 0, 0);
    check_win(9, 108, 109, ev(109), 7, 0, 1);
    chk("ovf_err", pw.line_err, 1);
    do_reset();
    chk("err_cleared", pw.line_err, 0);

    // sol mid-line abandons pending center
    got.delete();
    beat(1, 1, 0, 8'd5); beat(1, 0, 0, 8'd6);
    beat(1, 1, 0, 8'd8); beat(1, 0, 0, 8'd9); beat(1, 0, 1, 8'd10);
    idle(5);
    chk("abandon_count", got.size(), 4);
    check_win(0, ev(5), 5, 6, 0, 1, 0);
    check_win(1, ev(8), 8, 9, 0, 1, 0);
    check_win(3, 9, 10, ev(10), 2, 0, 1);
    chk("abandon_err", pw.line_err, 1);
    do_reset();

    // async reset during RUN
    got.delete();
    beat(1, 1, 0, 8'd11); beat(1, 0, 0, 8'd12); beat(1, 0, 0, 8'd13);
    chk("pre_rst_valid", pw.out_valid, 1);
    chk("pre_rst_center", pw.out_center, 12);
    reset = 1'b0;
    #1;
    chk("arst_valid", pw.out_valid, 0);
    chk("arst_left", pw.out_left, 0);
    chk("arst_center", pw.out_center, 0);
    chk("arst_right", pw.out_right, 0);
    chk("arst_col", pw.out_col, 0);
    idle(1);
    reset = 1'b1;
    got.delete();
    beat(1, 0, 0, 8'd77); idle(4);
    chk("drop_count", got.size(), 0);
    chk("drop_err", pw.line_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
